// File: rtl/timer_counter_param.sv
// WIDTH-bit up/down timer counter with selectable tick source, load, optional
// auto-reload, and overflow/underflow pulses with sticky flags.
module timer_counter_param #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 3
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             enable,
    input  logic             down,
    input  logic [1:0]       clk_sel,
    input  logic             tick_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] counter_value,
    output logic             ovf_pulse,
    output logic             udf_pulse,
    output logic             ovf_flag,
    output logic             udf_flag
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic               sync1, sync2, hist;
    logic               ext_tick;
    logic [PRESC_W-1:0] presc;
    logic               src_tick, tick;
    logic [WIDTH-1:0]   cnt_nxt;
    logic               ovf_nxt, udf_nxt;

    // External tick synchroniser runs regardless of enable so edges are never stale
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= tick_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign ext_tick = sync2 & ~hist;

    always_ff @(posedge PCLK) begin
        if (PRESET || !enable) presc <= '0;
        else                   presc <= presc + PRESC_W'(1);
    end

    always_comb begin
        src_tick = 1'b0;
        case (clk_sel)
            2'b00:   src_tick = ext_tick;
            2'b01:   src_tick = presc[0];
            2'b10:   src_tick = &presc[1:0];
            default: src_tick = &presc;
        endcase
    end

    assign tick = enable & src_tick;

    always_comb begin
        cnt_nxt = counter_value;
        ovf_nxt = 1'b0;
        udf_nxt = 1'b0;
        if (load) begin
            cnt_nxt = load_value;
        end else if (tick && !down) begin
            if (counter_value == CNT_MAX) begin
                cnt_nxt = auto_reload ? load_value : '0;
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = counter_value + WIDTH'(1);
            end
        end else if (tick && down) begin
            if (counter_value == '0) begin
                cnt_nxt = auto_reload ? load_value : CNT_MAX;
                udf_nxt = 1'b1;
            end else begin
                cnt_nxt = counter_value - WIDTH'(1);
            end
        end
    end

    // A set in the same cycle as flag_clr wins so no event is lost
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            counter_value <= '0;
            ovf_pulse     <= 1'b0;
            udf_pulse     <= 1'b0;
            ovf_flag      <= 1'b0;
            udf_flag      <= 1'b0;
        end else begin
            counter_value <= cnt_nxt;
            ovf_pulse     <= ovf_nxt;
            udf_pulse     <= udf_nxt;
            ovf_flag      <= ovf_nxt | (ovf_flag & ~flag_clr);
            udf_flag      <= udf_nxt | (udf_flag & ~flag_clr);
        end
    end

endmodule

// File: tb/tb_timer_counter_param.sv
// Vector table plus scoreboard queue for timer_counter_param; the external
// tick path is exercised by a hand-written edge sequence.
module tb_timer_counter_param;

    localparam int W  = 8;
    localparam int PW = 3;

    logic         PCLK = 1'b0;
    logic         PRESET, enable, down, tick_in, load, auto_reload, flag_clr;
    logic [1:0]   clk_sel;
    logic [W-1:0] load_value, counter_value;
    logic         ovf_pulse, udf_pulse, ovf_flag, udf_flag;

    timer_counter_param #(.WIDTH(W), .PRESC_W(PW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .enable(enable), .down(down),
        .clk_sel(clk_sel), .tick_in(tick_in), .load(load),
        .load_value(load_value), .auto_reload(auto_reload), .flag_clr(flag_clr),
        .counter_value(counter_value), .ovf_pulse(ovf_pulse), .udf_pulse(udf_pulse),
        .ovf_flag(ovf_flag), .udf_flag(udf_flag)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic         rst, en, dn;
        logic [1:0]   sel;
        logic         ld;
        logic [W-1:0] lv;
        logic         ar, fc;
        logic [W-1:0] cnt;
        logic         op, up, of, uf;
    } vec_t;

    vec_t         vecs[$];
    vec_t         sb[$];
    logic [W-1:0] ext_sb[$];
    int           checks = 0;
    int           errors = 0;

    task automatic add(input logic rst, en, dn, input logic [1:0] sel, input logic ld,
                       input logic [W-1:0] lv, input logic ar, fc, input logic [W-1:0] cnt,
                       input logic op, up, of, uf);
        vec_t t;
        t.rst = rst; t.en = en; t.dn = dn; t.sel = sel; t.ld = ld; t.lv = lv;
        t.ar = ar; t.fc = fc; t.cnt = cnt; t.op = op; t.up = up; t.of = of; t.uf = uf;
        vecs.push_back(t);
    endtask

    task automatic chk_vec(input string nm, input vec_t e);
        checks++;
        if (counter_value !== e.cnt || ovf_pulse !== e.op || udf_pulse !== e.up ||
            ovf_flag !== e.of || udf_flag !== e.uf) begin
            errors++;
            $display("FAIL %s: got cnt=%h op=%b up=%b of=%b uf=%b, want cnt=%h op=%b up=%b of=%b uf=%b",
                     nm, counter_value, ovf_pulse, udf_pulse, ovf_flag, udf_flag,
                     e.cnt, e.op, e.up, e.of, e.uf);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d..%0d", nm, got, lo, hi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t         e;
        logic [W-1:0] prev;
        int           changes, at;

        PRESET = 1'b1; enable = 1'b0; down = 1'b0; clk_sel = 2'b00; tick_in = 1'b0;
        load = 1'b0; load_value = '0; auto_reload = 1'b0; flag_clr = 1'b0;

        //   rst en dn sel  ld lv     ar fc  cnt    op up of uf
        add(1, 0, 0, 2'd0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);  // reset state
        // up wrap, PCLK/2
        add(0, 0, 0, 2'd0, 1, 8'hFE, 0, 0, 8'hFE, 0, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFE, 0, 0, 8'hFE, 0, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFE, 0, 0, 8'hFF, 0, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFE, 0, 0, 8'hFF, 0, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFE, 0, 0, 8'h00, 1, 0, 1, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFE, 0, 0, 8'h00, 0, 0, 1, 0);
        add(0, 0, 0, 2'd1, 0, 8'hFE, 0, 1, 8'h00, 0, 0, 0, 0);
        // down wrap with auto-reload
        add(0, 0, 0, 2'd1, 1, 8'h01, 0, 0, 8'h01, 0, 0, 0, 0);
        add(0, 1, 1, 2'd1, 0, 8'h10, 1, 0, 8'h01, 0, 0, 0, 0);
        add(0, 1, 1, 2'd1, 0, 8'h10, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 1, 2'd1, 0, 8'h10, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 1, 2'd1, 0, 8'h10, 1, 0, 8'h10, 0, 1, 0, 1);
        add(0, 1, 1, 2'd1, 0, 8'h10, 1, 0, 8'h10, 0, 0, 0, 1);
        add(0, 0, 1, 2'd1, 0, 8'h10, 1, 1, 8'h10, 0, 0, 0, 0);
        // load beats a wrap tick at max
        add(0, 0, 0, 2'd1, 1, 8'hFF, 0, 0, 8'hFF, 0, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFF, 0, 0, 8'hFF, 0, 0, 0, 0);
        add(0, 1, 0, 2'd1, 1, 8'h5A, 0, 0, 8'h5A, 0, 0, 0, 0);
        // flag_clr coincident with overflow leaves the flag set
        add(0, 0, 0, 2'd1, 1, 8'hFF, 0, 0, 8'hFF, 0, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFF, 0, 0, 8'hFF, 0, 0, 0, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFF, 0, 1, 8'h00, 1, 0, 1, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFF, 0, 0, 8'h00, 0, 0, 1, 0);
        add(0, 1, 0, 2'd1, 0, 8'hFF, 0, 0, 8'h01, 0, 0, 1, 0);
        // disabled: holds, load still works, flags untouched by load
        add(0, 0, 0, 2'd1, 1, 8'h42, 0, 0, 8'h42, 0, 0, 1, 0);
        add(0, 0, 0, 2'd1, 0, 8'h42, 0, 0, 8'h42, 0, 0, 1, 0);
        add(0, 0, 0, 2'd1, 0, 8'h42, 0, 0, 8'h42, 0, 0, 1, 0);
        add(0, 0, 0, 2'd1, 1, 8'h99, 0, 0, 8'h99, 0, 0, 1, 0);
        // reset mid-count at 0x37, then PCLK/4 restarts from a cleared prescaler
        add(0, 0, 0, 2'd1, 1, 8'h36, 0, 0, 8'h36, 0, 0, 1, 0);
        add(0, 1, 0, 2'd1, 0, 8'h36, 0, 0, 8'h36, 0, 0, 1, 0);
        add(0, 1, 0, 2'd1, 0, 8'h36, 0, 0, 8'h37, 0, 0, 1, 0);
        add(0, 1, 0, 2'd1, 0, 8'h36, 0, 0, 8'h37, 0, 0, 1, 0);
        add(1, 1, 0, 2'd1, 0, 8'h36, 0, 0, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 2'd2, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 2'd2, 0, 8'h00, 0, 0, 8'h01, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            add(0, 1, 0, 2'd2, 0, 8'h00, 0, 0, 8'h01, 0, 0, 0, 0);
        add(0, 1, 0, 2'd2, 0, 8'h00, 0, 0, 8'h02, 0, 0, 0, 0);
        // PCLK/8
        for (int i = 0; i < 7; i++)
            add(0, 1, 0, 2'd3, 0, 8'h00, 0, 0, 8'h02, 0, 0, 0, 0);
        add(0, 1, 0, 2'd3, 0, 8'h00, 0, 0, 8'h03, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge PCLK);
            PRESET = vecs[i].rst; enable = vecs[i].en; down = vecs[i].dn;
            clk_sel = vecs[i].sel; load = vecs[i].ld; load_value = vecs[i].lv;
            auto_reload = vecs[i].ar; flag_clr = vecs[i].fc;
            sb.push_back(vecs[i]);
            @(posedge PCLK); #1;
            e = sb.pop_front();
            chk_vec($sformatf("vec%0d", i), e);
        end

        // external edges: 5 rising edges 7 PCLK apart from 0x00
        @(negedge PCLK);
        PRESET = 1'b0; enable = 1'b0; down = 1'b0; clk_sel = 2'b00; load = 1'b1;
        load_value = '0; auto_reload = 1'b0; flag_clr = 1'b0; tick_in = 1'b0;
        @(negedge PCLK);
        load = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge PCLK);
            tick_in = 1'b1;
            ext_sb.push_back(W'(k));
            changes = 0; at = 0;
            for (int c = 1; c <= 7; c++) begin
                prev = counter_value;
                @(posedge PCLK); #1;
                if (counter_value !== prev) begin
                    changes++;
                    at = c;
                end
                if (c == 3) tick_in = 1'b0;
            end
            e = vecs[0];
            e.cnt = ext_sb.pop_front(); e.op = 1'b0; e.up = 1'b0; e.of = 1'b0; e.uf = 1'b0;
            chk_vec($sformatf("ext_val%0d", k), e);
            chk_int($sformatf("ext_changes%0d", k), changes, 1, 1);
            chk_int($sformatf("ext_latency%0d", k), at, 2, 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
